// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter -- iterative AES forward cipher, one round per clock.
//
// A plaintext block and its pre-expanded key schedule are taken over a
// valid/ready handshake. Rounds then run on a single shared round datapath, and
// the ciphertext is presented over a valid/ready handshake.
//
// Parameters
//   Nr         number of rounds: 10, 12 or 14 (AES-128/192/256)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   Text/RoundKeys valid
//   in_ready   block can accept a new plaintext (registered)
//   Text       plaintext, byte0 = bits 0:7, column-major state
//   RoundKeys  round key i = RoundKeys[128*i +: 128]
//   out_valid  Ciphered holds a completed result (registered)
//   out_ready  downstream accepts Ciphered
//   Ciphered   ciphertext, same byte order as Text (registered)
//   busy       high while rounds are in progress (registered)
//
// Build option
//   CIPHER_KEY_LATCH_EN  When this is defined, round keys 1..Nr are captured at accept,
//                        so the RoundKeys source is free to change afterwards.
//                        When it is not defined, the keys are read live each round,
//                        and an assertion checks that they stay stable while busy.

module aes_cipher_iter #(
  parameter int Nr = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:127]            Text,
  input  logic [0:128*(Nr+1)-1]   RoundKeys,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:127]            Ciphered,
  output logic                    busy
);

  localparam int CtrW = $clog2(Nr + 1);
  localparam logic [CtrW-1:0] LastRound = CtrW'(Nr);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsmT;

  fsmT             fsmReg, fsmNext;
  logic [127:0]    stateReg, stateNext;
  logic [127:0]    cipheredReg, cipheredNext;
  logic [CtrW-1:0] ctrReg, ctrNext;
  logic            inReadyReg, inReadyNext;
  logic            outValidReg, outValidNext;
  logic            busyReg, busyNext;
  logic            accept;

  // Keys 1..Nr are the only ones used after accept; key 0 is always taken live.
  logic [0:128*Nr-1] keySrc;
  logic [127:0]      keyArr [1:Nr];
  logic [127:0]      roundKey;
  logic [127:0]      shifted;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers. The S-box is computed as multiplicative inverse (x^254)
  // followed by the affine transform, which avoids a 256-entry table.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // SubBytes and ShiftRows combined. Byte b sits at bits [127-8b -: 8] with
  // row b%4 and column b/4; row r rotates left by r columns.
  function automatic logic [127:0] subShift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      src = 4 * (((b / 4) + (b % 4)) % 4) + (b % 4);
      o[127-8*b -: 8] = sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Key source
  // ---------------------------------------------------------------------------
`ifdef CIPHER_KEY_LATCH_EN
  logic [0:128*Nr-1] keyReg;

  always_ff @(posedge clk) begin
    if (accept) keyReg <= RoundKeys[128 +: 128*Nr];
  end

  assign keySrc = keyReg;
`else
  assign keySrc = RoundKeys[128 +: 128*Nr];

  // Keys are read live, so they must not move while rounds are running.
  keyHoldA: assert property (@(posedge clk) disable iff (!reset)
                             busyReg |-> $stable(RoundKeys));
`endif

  for (genvar gi = 1; gi <= Nr; gi++) begin : gKey
    assign keyArr[gi] = keySrc[128*(gi-1) +: 128];
  end

  assign roundKey = keyArr[ctrReg];
  assign shifted  = subShift(stateReg);
  assign accept   = in_valid && inReadyReg && (fsmReg == IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsmReg      <= IDLE;
      stateReg    <= '0;
      cipheredReg <= '0;
      ctrReg      <= '0;
      inReadyReg  <= 1'b1;
      outValidReg <= 1'b0;
      busyReg     <= 1'b0;
    end else begin
      fsmReg      <= fsmNext;
      stateReg    <= stateNext;
      cipheredReg <= cipheredNext;
      ctrReg      <= ctrNext;
      inReadyReg  <= inReadyNext;
      outValidReg <= outValidNext;
      busyReg     <= busyNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fsmNext      = fsmReg;
    stateNext    = stateReg;
    cipheredNext = cipheredReg;
    ctrNext      = ctrReg;
    inReadyNext  = inReadyReg;
    outValidNext = outValidReg;
    busyNext     = busyReg;

    case (fsmReg)
      IDLE: begin
        if (accept) begin
          stateNext   = Text ^ RoundKeys[0 +: 128];
          ctrNext     = CtrW'(1);
          fsmNext     = ROUND;
          inReadyNext = 1'b0;
          busyNext    = 1'b1;
        end
      end

      ROUND: begin
        if (ctrReg == LastRound) begin
          // Final round has no MixColumns; the counter stays at Nr.
          stateNext    = shifted ^ roundKey;
          cipheredNext = shifted ^ roundKey;
          outValidNext = 1'b1;
          busyNext     = 1'b0;
          fsmNext      = DONE;
        end else begin
          stateNext = mixColumns(shifted) ^ roundKey;
          ctrNext   = ctrReg + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          outValidNext = 1'b0;
          inReadyNext  = 1'b1;
          ctrNext      = '0;
          fsmNext      = IDLE;
        end
      end

      default: begin
        fsmNext = IDLE;
      end
    endcase
  end

  assign in_ready  = inReadyReg;
  assign out_valid = outValidReg;
  assign busy      = busyReg;
  assign Ciphered  = cipheredReg;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Testbench for aes_cipher_iter. It runs an Nr=10 instance and an Nr=14 instance,
// using FIPS-197 known-answer vectors and a scoreboard of expected ciphertexts.

module tb_aes_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          in_valid10, in_ready10, out_valid10, out_ready10, busy10;
  logic [0:127]  text10, ct10;
  logic [0:1407] rk10;

  logic          in_valid14, in_ready14, out_valid14, out_ready14, busy14;
  logic [0:127]  text14, ct14;
  logic [0:1919] rk14;

  aes_cipher_iter #(.Nr(10)) dut10 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid10), .in_ready(in_ready10),
    .Text(text10), .RoundKeys(rk10),
    .out_valid(out_valid10), .out_ready(out_ready10),
    .Ciphered(ct10), .busy(busy10)
  );

  aes_cipher_iter #(.Nr(14)) dut14 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid14), .in_ready(in_ready14),
    .Text(text14), .RoundKeys(rk14),
    .out_valid(out_valid14), .out_ready(out_ready14),
    .Ciphered(ct14), .busy(busy14)
  );

  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  int nVec = 0;
  int nMis = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } expT;

  expT q10[$];
  expT q14[$];

  logic [7:0] sboxTab [0:255];
  logic [0:1919] k128a, k128b, k256;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // S-box built by walking the multiplicative group with generator 3.
  task automatic buildSbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sboxTab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxTab[0] = 8'h63;
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
  endfunction

  // The key is left-aligned in 256 bits; round key r lands at [128*r +: 128].
  function automatic logic [0:1919] expandKey(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   w [0:59];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] rk;
    rc = 8'h01;
    rk = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  // Drive one block into the selected instance, then push its expectation.
  // The task returns on the falling edge that follows the accept edge.
  task automatic sendTxn(input int sel, input logic [127:0] pt,
                         input logic [0:1919] rk, input logic [127:0] exp);
    int  n;
    expT e;
    n = 0;
    @(negedge clk);
    while (!(sel == 10 ? in_ready10 : in_ready14) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checkVal("in_ready_wait", (sel == 10 ? in_ready10 : in_ready14), 1);
      return;
    end
    if (sel == 10) begin
      text10 = pt; rk10 = rk[0:1407]; in_valid10 = 1'b1;
    end else begin
      text14 = pt; rk14 = rk; in_valid14 = 1'b1;
    end
    @(negedge clk);
    e.ct  = exp;
    e.acc = cyc;
    // Text is sampled only at accept, so scramble it straight away.
    if (sel == 10) begin
      in_valid10 = 1'b0;
      text10 = {$urandom, $urandom, $urandom, $urandom};
      q10.push_back(e);
    end else begin
      in_valid14 = 1'b0;
      text14 = {$urandom, $urandom, $urandom, $urandom};
      q14.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q10.size() != 0 || q14.size() != 0 || out_valid10 || out_valid14) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkVal("drain_pending", q10.size() + q14.size(), 0);
  endtask

  // Scoreboard: every rising out_valid pops one expectation.
  logic prevOv10 = 1'b0;
  logic prevOv14 = 1'b0;
  always @(negedge clk) begin
    expT e;
    if (out_valid10 && !prevOv10) begin
      if (q10.size() == 0) begin
        checkVal("ct10_unexpected", q10.size(), 1);
      end else begin
        e = q10.pop_front();
        checkVal("ct10", ct10, e.ct);
        checkVal("lat10", cyc - e.acc, 10);
        $display("txn dut10 ct=%h latency=%0d", ct10, cyc - e.acc);
      end
    end
    if (out_valid14 && !prevOv14) begin
      if (q14.size() == 0) begin
        checkVal("ct14_unexpected", q14.size(), 1);
      end else begin
        e = q14.pop_front();
        checkVal("ct14", ct14, e.ct);
        checkVal("lat14", cyc - e.acc, 14);
        $display("txn dut14 ct=%h latency=%0d", ct14, cyc - e.acc);
      end
    end
    prevOv10 <= out_valid10;
    prevOv14 <= out_valid14;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    in_valid10 = 1'b0; out_ready10 = 1'b1; text10 = '0; rk10 = '0;
    in_valid14 = 1'b0; out_ready14 = 1'b1; text14 = '0; rk14 = '0;
    buildSbox();
    k128a = expandKey({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    k128b = expandKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    k256  = expandKey(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);

    // Reset state
    repeat (3) @(negedge clk);
    checkVal("rst_in_ready10", in_ready10, 1);
    checkVal("rst_out_valid10", out_valid10, 0);
    checkVal("rst_busy10", busy10, 0);
    checkVal("rst_ct10", ct10, 0);
    checkVal("rst_in_ready14", in_ready14, 1);
    checkVal("rst_busy14", busy14, 0);
    reset = 1'b1;
    @(negedge clk);

    // T1: AES-128 known answer and latency
    sendTxn(10, PT1, k128a, CT1);
    checkVal("t1_busy", busy10, 1);
    checkVal("t1_in_ready", in_ready10, 0);
    drain();
    checkVal("t1_idle_in_ready", in_ready10, 1);

    // T2: second AES-128 vector
    sendTxn(10, PT2, k128b, CT2);
    drain();

    // T3: AES-256 with 14 rounds
    sendTxn(14, PT2, k256, CT3);
    checkVal("t3_busy", busy14, 1);
    drain();

    // T4: backpressure, then back-to-back blocks
    out_ready10 = 1'b0;
    sendTxn(10, PT1, k128a, CT1);
    n = 0;
    while (!out_valid10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkVal("t4_out_valid", out_valid10, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkVal("t4_ct_hold", ct10, CT1);
      checkVal("t4_in_ready_low", in_ready10, 0);
    end
    out_ready10 = 1'b1;
    @(negedge clk);
    checkVal("t4_out_valid_drop", out_valid10, 0);
    checkVal("t4_in_ready_back", in_ready10, 1);
    sendTxn(10, PT1, k128a, CT1);
    sendTxn(10, PT2, k128b, CT2);
    drain();

    // T5: reset in the middle of a block (counter at 5)
    sendTxn(10, PT1, k128a, CT1);
    repeat (4) @(negedge clk);
    checkVal("t5_pre_busy", busy10, 1);
    reset = 1'b0;
    #1;
    checkVal("t5_out_valid", out_valid10, 0);
    checkVal("t5_busy", busy10, 0);
    checkVal("t5_in_ready", in_ready10, 1);
    checkVal("t5_ct_clear", ct10, 0);
    q10.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sendTxn(10, PT1, k128a, CT1);
    drain();

`ifdef CIPHER_KEY_LATCH_EN
    // T6: the key source changes one cycle after accept
    sendTxn(10, PT1, k128a, CT1);
    for (int i = 0; i < 44; i++) rk10[32*i +: 32] = $urandom;
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
